// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD card arbiter: controller states,
// client indices and the latched operation encoding.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic CL_LOADER = 1'b0;
    localparam logic CL_DISK   = 1'b1;

    // Read wins whenever rd is asserted, so rd&wr collapses to a read.
    function automatic op_t decode_op(input logic rd);
        return rd ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/sd_arb_watchdog.sv
// Transfer watchdog for the SD card arbiter. Counts enabled cycles since the
// last clear and flags expiry once LIMIT cycles have been spent. Only
// instantiated when SD_ARB_TIMEOUT_EN is defined.
module sd_arb_watchdog #(
    parameter logic [31:0] LIMIT = 32'd2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    assign expired = enable && (count == (LIMIT - 32'd1));

    // Cycle counter: restarts on clear, saturates once expiry is reached.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 32'd0;
        end else if (enable && !expired) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/sd_card_arbiter.sv
// Two-client round-robin arbiter in front of a single SD card controller.
// Client 0 is the ROM/palette loader, client 1 the disk drive. The owner's
// address and operation are latched at grant time; controller status is
// forwarded only to the owner.
// Optional feature: define SD_ARB_TIMEOUT_EN to add a transfer watchdog that
// aborts a stuck transfer after TIMEOUT_CYCLES and reports it on c*_err.
module sd_card_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] c0_lba,
    input  logic        c0_rd,
    input  logic        c0_wr,
    output logic        c0_busy,
    output logic        c0_done,
    output logic        c0_strobe,
    output logic        c0_err,
    input  logic [31:0] c1_lba,
    input  logic        c1_rd,
    input  logic        c1_wr,
    output logic        c1_busy,
    output logic        c1_done,
    output logic        c1_strobe,
    output logic        c1_err,
    output logic [1:0]  grant,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_busy,
    input  logic        sd_done,
    input  logic        sd_rd_byte_strobe
);

    state_t state, state_next;
    op_t    op;
    logic   last_served;
    logic   req0, req1, any_req, pick;
    logic   expired;

    assign req0    = c0_rd | c0_wr;
    assign req1    = c1_rd | c1_wr;
    assign any_req = req0 | req1;

`ifdef SD_ARB_TIMEOUT_EN
    logic timed_out;

    sd_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == IDLE) && any_req),
        .enable  ((state == ISSUE) || (state == BUSY)),
        .expired (expired)
    );

    // Remember that the current transfer ended by timeout, for the err pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            timed_out <= 1'b0;
        end else if ((state == IDLE) && any_req) begin
            timed_out <= 1'b0;
        end else if (expired) begin
            timed_out <= 1'b1;
        end
    end

    assign c0_err = c0_done && timed_out;
    assign c1_err = c1_done && timed_out;
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign expired        = 1'b0;
    assign c0_err         = 1'b0;
    assign c1_err         = 1'b0;
`endif

    // Round-robin pick: on contention the client not served last wins.
    always_comb begin
        pick = CL_LOADER;
        if (req0 && req1) begin
            pick = (last_served == CL_DISK) ? CL_LOADER : CL_DISK;
        end else if (req1) begin
            pick = CL_DISK;
        end
    end

    // Next-state logic; early sd_done or watchdog expiry both end the transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = ISSUE;
            ISSUE: begin
                if (expired || sd_done) begin
                    state_next = DONE;
                end else if (sd_busy) begin
                    state_next = BUSY;
                end
            end
            BUSY:  if (expired || sd_done) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus grant, address and op latched at grant time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            sd_lba      <= 32'd0;
            op          <= OP_READ;
            last_served <= CL_DISK;
        end else begin
            state <= state_next;
            if ((state == IDLE) && any_req) begin
                grant  <= (pick == CL_DISK) ? 2'b10 : 2'b01;
                sd_lba <= (pick == CL_DISK) ? c1_lba : c0_lba;
                op     <= decode_op((pick == CL_DISK) ? c1_rd : c0_rd);
            end
            if (state == DONE) begin
                grant       <= 2'b00;
                last_served <= grant[1];
            end
        end
    end

    assign sd_rd     = (state == ISSUE) && (op == OP_READ);
    assign sd_wr     = (state == ISSUE) && (op == OP_WRITE);
    assign c0_busy   = grant[0] && sd_busy;
    assign c1_busy   = grant[1] && sd_busy;
    assign c0_strobe = grant[0] && sd_rd_byte_strobe;
    assign c1_strobe = grant[1] && sd_rd_byte_strobe;
    assign c0_done   = (state == DONE) && grant[0];
    assign c1_done   = (state == DONE) && grant[1];

endmodule

// File: tb/tb_sd_card_arbiter.sv
// Self-checking bench for sd_card_arbiter: a per-cycle vector table for the
// basic, contention and rd&wr flows, then hand-written multi-cycle sequences
// for strobe gating, reset mid-transfer and the watchdog (SD_ARB_TIMEOUT_EN).
module tb_sd_card_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] c0_lba, c1_lba;
    logic        c0_rd, c0_wr, c1_rd, c1_wr;
    logic        c0_busy, c0_done, c0_strobe, c0_err;
    logic        c1_busy, c1_done, c1_strobe, c1_err;
    logic [1:0]  grant;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_busy, sd_done, sd_rd_byte_strobe;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    sd_card_arbiter #(
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .c0_lba            (c0_lba),
        .c0_rd             (c0_rd),
        .c0_wr             (c0_wr),
        .c0_busy           (c0_busy),
        .c0_done           (c0_done),
        .c0_strobe         (c0_strobe),
        .c0_err            (c0_err),
        .c1_lba            (c1_lba),
        .c1_rd             (c1_rd),
        .c1_wr             (c1_wr),
        .c1_busy           (c1_busy),
        .c1_done           (c1_done),
        .c1_strobe         (c1_strobe),
        .c1_err            (c1_err),
        .grant             (grant),
        .sd_lba            (sd_lba),
        .sd_rd             (sd_rd),
        .sd_wr             (sd_wr),
        .sd_busy           (sd_busy),
        .sd_done           (sd_done),
        .sd_rd_byte_strobe (sd_rd_byte_strobe)
    );

    // stim: {c0_rd, c0_wr, c1_rd, c1_wr, sd_busy, sd_done, strobe}
    // flags: {c0_busy, c1_busy, c0_done, c1_done}; strb: {c0_strobe, c1_strobe}
    typedef struct {
        logic        rst;
        logic [6:0]  stim;
        logic [1:0]  grant;
        logic        rd;
        logic        wr;
        logic [3:0]  flags;
        logic [1:0]  strb;
        logic [31:0] lba;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(input logic rst, input logic [6:0] stim,
                                input logic [1:0] g, input logic rd, input logic wr,
                                input logic [3:0] fl, input logic [1:0] st,
                                input logic [31:0] lba);
        vec_t v;
        v.rst = rst; v.stim = stim; v.grant = g; v.rd = rd; v.wr = wr;
        v.flags = fl; v.strb = st; v.lba = lba;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [6:0] stim);
        {c0_rd, c0_wr, c1_rd, c1_wr, sd_busy, sd_done, sd_rd_byte_strobe} = stim;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        applyStimulus(7'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic waitGrant(input logic [1:0] want, input string name);
        int n = 0;
        #1;
        while (grant !== want && n < 20) begin
            tick();
            #1;
            n++;
        end
        checkOutput(name, {30'd0, grant}, {30'd0, want});
    endtask

    initial begin
        int c0s, c1s, c0b, c1b, doneCnt, rdCnt, doneAt;

        // Single read from client 0 (lba 5), busy after 3 cycles.
        vecs[0]  = mk(0, 7'b1000000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd0);
        vecs[1]  = mk(0, 7'b1000000, 2'b01, 1, 0, 4'b0000, 2'b00, 32'd5);
        vecs[2]  = mk(0, 7'b1000000, 2'b01, 1, 0, 4'b0000, 2'b00, 32'd5);
        vecs[3]  = mk(0, 7'b1000100, 2'b01, 1, 0, 4'b1000, 2'b00, 32'd5);
        vecs[4]  = mk(0, 7'b0000100, 2'b01, 0, 0, 4'b1000, 2'b00, 32'd5);
        vecs[5]  = mk(0, 7'b0000101, 2'b01, 0, 0, 4'b1000, 2'b10, 32'd5);
        vecs[6]  = mk(0, 7'b0000110, 2'b01, 0, 0, 4'b1000, 2'b00, 32'd5);
        vecs[7]  = mk(0, 7'b0000000, 2'b01, 0, 0, 4'b0010, 2'b00, 32'd5);
        vecs[8]  = mk(0, 7'b0000000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd5);
        vecs[9]  = mk(1, 7'b0000000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd0);
        // Contention after reset: c0 read first, then c1 write beats re-asserted c0.
        vecs[10] = mk(0, 7'b1001000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd0);
        vecs[11] = mk(0, 7'b1001100, 2'b01, 1, 0, 4'b1000, 2'b00, 32'd5);
        vecs[12] = mk(0, 7'b0001110, 2'b01, 0, 0, 4'b1000, 2'b00, 32'd5);
        vecs[13] = mk(0, 7'b1001000, 2'b01, 0, 0, 4'b0010, 2'b00, 32'd5);
        vecs[14] = mk(0, 7'b1001000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd5);
        vecs[15] = mk(0, 7'b1001000, 2'b10, 0, 1, 4'b0000, 2'b00, 32'd9);
        vecs[16] = mk(0, 7'b1001100, 2'b10, 0, 1, 4'b0100, 2'b00, 32'd9);
        vecs[17] = mk(0, 7'b1000111, 2'b10, 0, 0, 4'b0100, 2'b01, 32'd9);
        vecs[18] = mk(0, 7'b1000000, 2'b10, 0, 0, 4'b0001, 2'b00, 32'd9);
        vecs[19] = mk(0, 7'b1000000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd9);
        // sd_done while still in ISSUE completes the transfer.
        vecs[20] = mk(0, 7'b1000010, 2'b01, 1, 0, 4'b0000, 2'b00, 32'd5);
        vecs[21] = mk(0, 7'b0000000, 2'b01, 0, 0, 4'b0010, 2'b00, 32'd5);
        vecs[22] = mk(0, 7'b0000000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd5);
        // c1 rd&wr together: treated as a read.
        vecs[23] = mk(0, 7'b0011000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd5);
        vecs[24] = mk(0, 7'b0011000, 2'b10, 1, 0, 4'b0000, 2'b00, 32'd9);
        vecs[25] = mk(0, 7'b0011100, 2'b10, 1, 0, 4'b0100, 2'b00, 32'd9);
        vecs[26] = mk(0, 7'b0000110, 2'b10, 0, 0, 4'b0100, 2'b00, 32'd9);
        vecs[27] = mk(0, 7'b0000000, 2'b10, 0, 0, 4'b0001, 2'b00, 32'd9);
        vecs[28] = mk(0, 7'b0000000, 2'b00, 0, 0, 4'b0000, 2'b00, 32'd9);

        c0_lba = 32'd5;
        c1_lba = 32'd9;
        reset  = 1'b1;
        applyStimulus(7'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        #1;
        checkOutput("reset grant", {30'd0, grant}, 32'd0);
        checkOutput("reset sd_lba", sd_lba, 32'd0);
        checkOutput("reset rd/wr/done/err",
                    {26'd0, sd_rd, sd_wr, c0_done, c1_done, c0_err, c1_err}, 32'd0);

        for (int i = 0; i < 29; i++) begin
            if (vecs[i].rst) begin
                pulseReset();
            end else begin
                applyStimulus(vecs[i].stim);
                #1;
                checkOutput($sformatf("row %0d grant", i), {30'd0, grant}, {30'd0, vecs[i].grant});
                checkOutput($sformatf("row %0d sd_rd/sd_wr", i), {30'd0, sd_rd, sd_wr},
                            {30'd0, vecs[i].rd, vecs[i].wr});
                checkOutput($sformatf("row %0d busy/done", i),
                            {28'd0, c0_busy, c1_busy, c0_done, c1_done}, {28'd0, vecs[i].flags});
                checkOutput($sformatf("row %0d strobes", i), {30'd0, c0_strobe, c1_strobe},
                            {30'd0, vecs[i].strb});
                checkOutput($sformatf("row %0d sd_lba", i), sd_lba, vecs[i].lba);
                checkOutput($sformatf("row %0d err", i), {30'd0, c0_err, c1_err}, 32'd0);
                tick();
            end
        end

        // Strobe gating: 512 byte strobes during a client 1 read.
        pulseReset();
        c1_rd = 1'b1;
        tick();
        waitGrant(2'b10, "gating grant c1");
        sd_busy = 1'b1;
        tick();
        c1_rd = 1'b0;
        c0s = 0; c1s = 0; c0b = 0; c1b = 0;
        for (int i = 0; i < 1024; i++) begin
            sd_rd_byte_strobe = (i % 2 == 0);
            #1;
            c0s += int'(c0_strobe);
            c1s += int'(c1_strobe);
            c0b += int'(c0_busy);
            c1b += int'(c1_busy);
            tick();
        end
        sd_rd_byte_strobe = 1'b0;
        checkOutput("gating c1_strobe count", c1s, 32'd512);
        checkOutput("gating c0_strobe count", c0s, 32'd0);
        checkOutput("gating c0_busy count", c0b, 32'd0);
        checkOutput("gating c1_busy count", c1b, 32'd1024);
        sd_done = 1'b1;
        tick();
        sd_done = 1'b0;
        sd_busy = 1'b0;
        #1;
        checkOutput("gating c1_done", {31'd0, c1_done}, 32'd1);
        tick();

        // Reset while BUSY: no done, grant cleared, pending c1 granted next.
        c0_rd = 1'b1;
        tick();
        waitGrant(2'b01, "rstbusy grant c0");
        sd_busy = 1'b1;
        tick();
        c0_rd = 1'b0;
        c1_rd = 1'b1;
        #1;
        checkOutput("rstbusy c1_busy gated", {31'd0, c1_busy}, 32'd0);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        sd_busy = 1'b0;
        #1;
        checkOutput("rstbusy grant cleared", {30'd0, grant}, 32'd0);
        checkOutput("rstbusy rd/wr/done", {28'd0, sd_rd, sd_wr, c0_done, c1_done}, 32'd0);
        tick();
        #1;
        checkOutput("rstbusy c1 granted next", {30'd0, grant}, 32'd2);
        checkOutput("rstbusy no c0_done", {31'd0, c0_done}, 32'd0);
        c1_rd   = 1'b0;
        sd_done = 1'b1;
        tick();
        sd_done = 1'b0;
        tick();
        tick();

        // Watchdog: client 0 read that never sees sd_busy.
        c0_rd = 1'b1;
        tick();
        waitGrant(2'b01, "stuck grant c0");
        c0_rd = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        doneAt = -1;
        for (int n = 0; n < 200 && doneAt < 0; n++) begin
            #1;
            if (c0_done) begin
                doneAt = n;
                checkOutput("timeout c0_err with done", {31'd0, c0_err}, 32'd1);
                checkOutput("timeout sd_rd dropped", {31'd0, sd_rd}, 32'd0);
            end
            tick();
        end
        checkOutput("timeout done cycle", doneAt, 32'd100);
        #1;
        checkOutput("timeout single pulse", {30'd0, c0_done, c0_err}, 32'd0);
        checkOutput("timeout back to idle", {30'd0, grant}, 32'd0);
`else
        doneCnt = 0;
        rdCnt   = 0;
        doneAt  = 0;
        for (int n = 0; n < 300; n++) begin
            #1;
            doneCnt += int'(c0_done | c0_err);
            rdCnt   += int'(sd_rd);
            tick();
        end
        checkOutput("no timeout done count", doneCnt, 32'd0);
        checkOutput("no timeout sd_rd held", rdCnt, 32'd300);
        #1;
        checkOutput("no timeout still granted", {30'd0, grant}, 32'd1);
        sd_done = 1'b1;
        tick();
        sd_done = 1'b0;
        #1;
        checkOutput("no timeout c0_done after sd_done", {30'd0, c0_done, c0_err},
                    {30'd0, 1'b1, 1'b0 + doneAt[0]});
        tick();
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
